// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C target engine.
//   state_e       : protocol FSM states
//   I2C_ACK/NACK  : SDA level of an acknowledge / not-acknowledge bit
//   RW_READ       : R/W bit value that selects a read (target transmits)
//   TX_IDLE_BYTE  : byte shifted out when the TX FIFO is empty (bus left released)
//   addr_match()  : 7-bit own-address compare on a received address byte
package i2c_slave_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    RX_BYTE,
    RX_ACK,
    TX_BYTE,
    TX_ACK,
    WAIT_STOP
  } state_e;

  localparam int unsigned BIT_CNT_W    = 3;
  localparam logic        I2C_ACK      = 1'b0;
  localparam logic        I2C_NACK     = 1'b1;
  localparam logic        RW_READ      = 1'b1;
  localparam logic [7:0]  TX_IDLE_BYTE = 8'hFF;

  // Upper seven bits of the address byte carry the target address.
  function automatic logic addr_match(input logic [7:0] addr_byte,
                                      input logic [6:0] own_addr);
    return addr_byte[7:1] == own_addr;
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes raw SCL/SDA into the core clock domain and flags bus events.
//   clk_i, rst_ni : core clock, synchronous active-low reset
//   scl_i, sda_i  : raw bus lines
//   sda_o         : synchronized SDA level (registered)
//   scl_rise_c    : synced SCL 0->1
//   scl_fall_c    : synced SCL 1->0
//   start_c       : SDA 1->0 while SCL high
//   stop_c        : SDA 0->1 while SCL high
module i2c_line_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_c,
  output logic scl_fall_c,
  output logic start_c,
  output logic stop_c
);

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_dly_q, scl_dly_d;
  logic                   sda_dly_q, sda_dly_d;
  logic                   scl_s;

  // Synchronizer chain (oldest sample at MSB) plus one delay stage for edges.
  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_i};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_i};
    scl_s      = scl_sync_q[SYNC_STAGES-1];
    sda_o      = sda_sync_q[SYNC_STAGES-1];
    scl_dly_d  = scl_s;
    sda_dly_d  = sda_o;
    scl_rise_c = scl_s & ~scl_dly_q;
    scl_fall_c = ~scl_s & scl_dly_q;
    start_c    = scl_s & sda_dly_q & ~sda_o;
    stop_c     = scl_s & ~sda_dly_q & sda_o;
  end

  // Reset to the idle-bus level so leaving reset never fakes an edge or STOP.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_dly_q  <= 1'b1;
      sda_dly_q  <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_dly_q  <= scl_dly_d;
      sda_dly_q  <= sda_dly_d;
    end
  end

endmodule

// File: rtl/i2c_slave_core.sv
// I2C target engine: decodes START/STOP, ACKs its 7-bit address, pushes
// written bytes to an RX FIFO port and shifts TX FIFO bytes out on reads.
//   i2c_core_clk_i, rst_ni : core clock (>= 8x SCL), synchronous active-low reset
//   scl_i, sda_i           : raw bus lines; sda_oe_o pulls SDA low when 1
//   own_addr_i             : 7-bit target address
//   tx_data_i/tx_valid_i   : TX FIFO head; tx_rd_o pops it
//   rx_data_o/rx_wr_o      : received byte and push pulse; rx_full_i blocks push
//   busy_o, start_o, stop_o, tx_underrun_o : bus status and event pulses
module i2c_slave_core
  import i2c_slave_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DATA_SIZE   = 8
) (
  input  logic                 i2c_core_clk_i,
  input  logic                 rst_ni,
  input  logic                 scl_i,
  input  logic                 sda_i,
  output logic                 sda_oe_o,
  input  logic [6:0]           own_addr_i,
  input  logic [DATA_SIZE-1:0] tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_rd_o,
  output logic [DATA_SIZE-1:0] rx_data_o,
  output logic                 rx_wr_o,
  input  logic                 rx_full_i,
  output logic                 busy_o,
  output logic                 start_o,
  output logic                 stop_o,
  output logic                 tx_underrun_o
);

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_SIZE - 1);

  logic sda_s, scl_rise_c, scl_fall_c, start_c, stop_c;

  state_e                 state_q, state_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_SIZE-1:0]   shift_q, shift_d;
  logic [DATA_SIZE-1:0]   rx_data_q, rx_data_d;
  logic                   rw_q, rw_d;
  logic                   ack_q, ack_d;
  logic                   phase_q, phase_d;
  logic                   sda_oe_q, sda_oe_d;
  logic                   busy_q, busy_d;
  logic                   rx_wr_q, rx_wr_d;
  logic                   tx_rd_q, tx_rd_d;
  logic                   start_q, start_d;
  logic                   stop_q, stop_d;
  logic                   underrun_q, underrun_d;

  logic [DATA_SIZE-1:0]   shift_in_c;
  logic [DATA_SIZE-1:0]   tx_byte_c;
  logic                   last_bit_c;

  i2c_line_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_line_sync (
    .clk_i      (i2c_core_clk_i),
    .rst_ni     (rst_ni),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .sda_o      (sda_s),
    .scl_rise_c (scl_rise_c),
    .scl_fall_c (scl_fall_c),
    .start_c    (start_c),
    .stop_c     (stop_c)
  );

  // Next state and outputs; START/STOP override every state.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    rw_d       = rw_q;
    ack_d      = ack_q;
    phase_d    = phase_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    rx_wr_d    = 1'b0;
    tx_rd_d    = 1'b0;
    start_d    = 1'b0;
    stop_d     = 1'b0;
    underrun_d = 1'b0;

    shift_in_c = {shift_q[DATA_SIZE-2:0], sda_s};
    tx_byte_c  = tx_valid_i ? tx_data_i : DATA_SIZE'(TX_IDLE_BYTE);
    last_bit_c = (bit_cnt_q == LAST_BIT);

    if (start_c) begin
      state_d   = ADDR;
      bit_cnt_d = '0;
      phase_d   = 1'b0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b1;
      start_d   = 1'b1;
    end else if (stop_c) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      phase_d   = 1'b0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      stop_d    = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: ;

        ADDR: begin
          if (scl_rise_c) begin
            shift_d   = shift_in_c;
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            if (last_bit_c) begin
              rw_d    = sda_s;
              phase_d = 1'b0;
              state_d = addr_match(8'(shift_in_c), own_addr_i) ? ADDR_ACK : WAIT_STOP;
            end
          end
        end

        // phase 0: drive ACK at the fall ending bit 8; phase 1: end of ACK slot.
        ADDR_ACK: begin
          if (scl_fall_c) begin
            if (!phase_q) begin
              sda_oe_d = 1'b1;
              phase_d  = 1'b1;
            end else begin
              phase_d   = 1'b0;
              bit_cnt_d = '0;
              if (rw_q == RW_READ) begin
                // First read byte is loaded on the same fall that frees the ACK.
                shift_d    = tx_byte_c;
                sda_oe_d   = ~tx_byte_c[DATA_SIZE-1];
                tx_rd_d    = tx_valid_i;
                underrun_d = ~tx_valid_i;
                state_d    = TX_BYTE;
              end else begin
                sda_oe_d = 1'b0;
                state_d  = RX_BYTE;
              end
            end
          end
        end

        RX_BYTE: begin
          if (scl_rise_c) begin
            shift_d   = shift_in_c;
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            if (last_bit_c) begin
              if (!rx_full_i) begin
                rx_data_d = shift_in_c;
                rx_wr_d   = 1'b1;
                ack_d     = I2C_ACK;
              end else begin
                ack_d     = I2C_NACK;
              end
              phase_d = 1'b0;
              state_d = RX_ACK;
            end
          end
        end

        RX_ACK: begin
          if (scl_fall_c) begin
            if (!phase_q) begin
              sda_oe_d = (ack_q == I2C_ACK);
              phase_d  = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              phase_d   = 1'b0;
              bit_cnt_d = '0;
              state_d   = (ack_q == I2C_ACK) ? RX_BYTE : WAIT_STOP;
            end
          end
        end

        // Each fall presents the next bit; the fall ending the last bit releases SDA.
        TX_BYTE: begin
          if (scl_fall_c) begin
            if (last_bit_c) begin
              sda_oe_d = 1'b0;
              phase_d  = 1'b0;
              state_d  = TX_ACK;
            end else begin
              shift_d   = {shift_q[DATA_SIZE-2:0], 1'b0};
              sda_oe_d  = ~shift_q[DATA_SIZE-2];
              bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            end
          end
        end

        // phase 0: wait for master ACK on the rise; phase 1: load next byte on the fall.
        TX_ACK: begin
          if (!phase_q) begin
            if (scl_rise_c) begin
              if (sda_s == I2C_ACK) begin
                phase_d = 1'b1;
              end else begin
                state_d = WAIT_STOP;
              end
            end
          end else if (scl_fall_c) begin
            phase_d    = 1'b0;
            bit_cnt_d  = '0;
            shift_d    = tx_byte_c;
            sda_oe_d   = ~tx_byte_c[DATA_SIZE-1];
            tx_rd_d    = tx_valid_i;
            underrun_d = ~tx_valid_i;
            state_d    = TX_BYTE;
          end
        end

        WAIT_STOP: sda_oe_d = 1'b0;

        default: begin
          state_d  = IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge i2c_core_clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      rx_data_q  <= '0;
      rw_q       <= 1'b0;
      ack_q      <= I2C_NACK;
      phase_q    <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      rx_wr_q    <= 1'b0;
      tx_rd_q    <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      rw_q       <= rw_d;
      ack_q      <= ack_d;
      phase_q    <= phase_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      rx_wr_q    <= rx_wr_d;
      tx_rd_q    <= tx_rd_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      underrun_q <= underrun_d;
    end
  end

  assign sda_oe_o      = sda_oe_q;
  assign rx_data_o     = rx_data_q;
  assign rx_wr_o       = rx_wr_q;
  assign tx_rd_o       = tx_rd_q;
  assign busy_o        = busy_q;
  assign start_o       = start_q;
  assign stop_o        = stop_q;
  assign tx_underrun_o = underrun_q;

endmodule

// File: doc/i2c_slave_core.md
Name: i2c_slave_core

Overview:
I2C target (responder) engine, the far-end counterpart of our I2C master datapath and its TX/RX FIFOs. It runs in the I2C core clock domain and oversamples SCL/SDA. It decodes START/STOP, matches a 7-bit own address and ACKs it. Received write bytes are pushed into an RX-FIFO-style write port. For read transfers, bytes are popped from a TX-FIFO-style read port and shifted onto SDA. It is used as the bus model/peer for the master and as a reusable target block.

Parameters:
SYNC_STAGES, 2, synchronizer flops on scl_i/sda_i (minimum 2)
DATA_SIZE, 8, byte width (fixed 8 for I2C; parameter for FIFO port alignment)

Ports:
i2c_core_clk_i  in  1  core clock; must be ≥ 8× SCL frequency
rst_ni  in  1  synchronous active-low reset, sampled on rising edge of i2c_core_clk_i
scl_i  in  1  raw SCL line
sda_i  in  1  raw SDA line
sda_oe_o  out  1  1 = pull SDA low (open-drain); 0 = release
own_addr_i  in  7  target address; quasi-static
tx_data_i  in  8  next byte to transmit (TX-FIFO head)
tx_valid_i  in  1  tx_data_i valid (TX-FIFO not empty)
tx_rd_o  out  1  1-cycle pop pulse when tx_data_i is loaded
rx_data_o  out  8  received data byte
rx_wr_o  out  1  1-cycle push pulse; rx_data_o valid in same cycle
rx_full_i  in  1  RX-FIFO full
busy_o  out  1  1 from START to STOP
start_o  out  1  1-cycle pulse on START / repeated START
stop_o  out  1  1-cycle pulse on STOP
tx_underrun_o  out  1  1-cycle pulse: read byte needed, tx_valid_i=0

Behaviour:
- Reset (rst_ni=0 at clock edge): state IDLE. All outputs 0, sda_oe_o=0, rx_data_o=8'h00. Shift register and bit counter cleared. Reset mid-transfer releases SDA on the next edge.
- Input path: scl_i/sda_i pass through SYNC_STAGES flops, then one delay flop for edge detection.
  - scl_rise / scl_fall: synced SCL 0→1 / 1→0.
  - START: synced SDA 1→0 while synced SCL=1. STOP: SDA 0→1 while SCL=1.
- START/STOP have priority over everything, from any state.
  - START: state ADDR, bit_cnt=0, sda_oe_o=0, busy_o=1, start_o pulse.
  - STOP: state IDLE, sda_oe_o=0, busy_o=0, stop_o pulse.
- SDA sampling and driving:
  - Sample SDA on scl_rise, MSB first.
  - Change sda_oe_o only in the cycle after scl_fall, never while SCL high.
- States:
  - IDLE: ignore SCL; leave only on START.
  - ADDR: shift 8 bits. On 8th scl_rise, compare shift[7:1] with own_addr_i; latch rw=shift[0]. Match → ADDR_ACK. Mismatch → WAIT_STOP, SDA never driven.
  - ADDR_ACK: on next scl_fall assert sda_oe_o. On following scl_fall release it. Then:
    - rw=0 → RX_BYTE.
    - rw=1 → TX_BYTE, loading the first byte in the same cycle.
  - RX_BYTE: shift 8 bits. On 8th scl_rise:
    - rx_full_i=0: rx_data_o←byte, rx_wr_o pulse, ack=1.
    - rx_full_i=1: no push, ack=0.
    - Then → RX_ACK.
  - RX_ACK: on scl_fall drive sda_oe_o=ack. On following scl_fall release; ack=1 → RX_BYTE, ack=0 → WAIT_STOP.
  - TX_BYTE byte load (on the scl_fall entering the byte):
    - tx_valid_i=1: shift←tx_data_i, tx_rd_o pulse.
    - tx_valid_i=0: shift←8'hFF, tx_underrun_o pulse.
    - Drive sda_oe_o = ~shift[7]; shift on each scl_fall.
    - After the 8th bit's scl_fall, release SDA → TX_ACK.
  - TX_ACK: sample master ACK on scl_rise. SDA=0 → TX_BYTE, loading next byte at next scl_fall. SDA=1 (NACK) → WAIT_STOP.
  - WAIT_STOP: SDA released; exit only via START/STOP.
- bit_cnt is 3 bits. A 9th-clock ACK slot is handled by the *_ACK states, so no wrap ambiguity.
- No clock stretching: SCL is never driven. General call and 10-bit addressing are not supported.

Decomposition:
- Package i2c_slave_pkg: state enum (IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, WAIT_STOP); constants I2C_ACK=1'b0, I2C_NACK=1'b1, RW_READ=1'b1, TX_IDLE_BYTE=8'hFF.
- Sub-module i2c_line_sync: synchronizer plus scl_rise/scl_fall/start/stop detection. Instanced once.

Test Plan:
- own_addr_i=7'h3A; master writes 8'h74 then 8'hA5, STOP → ACK both slots; one rx_wr_o pulse with rx_data_o=8'hA5; stop_o pulse, busy_o=0.
- Master sends address byte 8'h50 → sda_oe_o stays 0 through the ACK slot and rest of transfer; no rx_wr_o; state WAIT_STOP until STOP.
- Address byte 8'h75, tx_data_i=8'h3C, tx_valid_i=1, master NACKs → SDA bits 0,0,1,1,1,1,0,0; exactly one tx_rd_o pulse; SDA released after the byte.
- Address byte 8'h75, tx_valid_i=0 → tx_underrun_o pulse; SDA released for all 8 bits (8'hFF).
- Write to 8'h74 with rx_full_i=1 during data byte 8'h11 → NACK in data ACK slot; no rx_wr_o; WAIT_STOP.
- Repeated START after the 4th data bit → start_o pulse, state ADDR, bit_cnt=0. rst_ni=0 while sda_oe_o=1 → sda_oe_o=0 and busy_o=0 on the next clock edge.
